// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB initiator for the peripheral subsystem. Takes single read/write
//   commands over a valid/ready port, runs the APB SETUP/ACCESS sequence
//   towards the WDT (psel_0) or memory (psel_1) slave, and returns the result
//   on a one-cycle response pulse.
//
//   Optional feature macro: APB_TIMEOUT_EN
//     defined   : ACCESS aborts after TIMEOUT cycles with pready low (rsp_err=1)
//     undefined : ACCESS waits indefinitely, rsp_err stays 0
//
// Ports
//   pclk, preset          clock, asynchronous active-high reset
//   presetn               slave reset (~preset, combinational)
//   cmd_valid/cmd_ready   command handshake (cmd_ready combinational)
//   cmd_write/addr/wdata  command payload
//   rsp_valid/rdata/err   one-cycle response pulse with read data / abort flag
//   paddr, pwrite, pwdata APB request signals
//   psel_0, psel_1        slave selects (address MSB decodes)
//   penable               APB enable
//   prdata_x, pready_x    per-slave read data and ready
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    output logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel_0,
    output logic              psel_1,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata_0,
    input  logic              pready_0,
    input  logic [DATA_W-1:0] prdata_1,
    input  logic              pready_1
);

    // Parameter legality check at elaboration
    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT must be within 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_paddr,     w_paddr_nxt;
    logic               r_pwrite,    w_pwrite_nxt;
    logic [DATA_W-1:0]  r_pwdata,    w_pwdata_nxt;
    logic               r_psel_0,    w_psel_0_nxt;
    logic               r_psel_1,    w_psel_1_nxt;
    logic               r_penable,   w_penable_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
    logic               r_rsp_err,   w_rsp_err_nxt;

    logic               w_accept;
    logic               w_pready;
    logic [DATA_W-1:0]  w_prdata;
    logic               w_abort;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT - 1);
    logic [7:0]         r_to_cnt, w_to_cnt_nxt;
`endif

    assign presetn   = ~preset;
    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid & cmd_ready;

    // Only the selected slave's ready/data matter; the other is ignored
    assign w_pready  = r_psel_1 ? pready_1 : pready_0;
    assign w_prdata  = r_psel_1 ? prdata_1 : prdata_0;

`ifdef APB_TIMEOUT_EN
    // Successful completion wins over the limit on the same edge
    assign w_abort   = (r_state == S_ACCESS) && !w_pready && (r_to_cnt == TO_LIMIT);
`else
    assign w_abort   = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state     <= S_IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel_0    <= 1'b0;
            r_psel_1    <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_to_cnt    <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_psel_0    <= w_psel_0_nxt;
            r_psel_1    <= w_psel_1_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`ifdef APB_TIMEOUT_EN
            r_to_cnt    <= w_to_cnt_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_pready || w_abort) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless changed
    always_comb begin
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_psel_0_nxt    = r_psel_0;
        w_psel_1_nxt    = r_psel_1;
        w_penable_nxt   = r_penable;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
`ifdef APB_TIMEOUT_EN
        w_to_cnt_nxt    = r_to_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_paddr_nxt  = cmd_addr;
                    w_pwrite_nxt = cmd_write;
                    w_pwdata_nxt = cmd_wdata;
                    w_psel_0_nxt = ~cmd_addr[ADDR_W-1];
                    w_psel_1_nxt =  cmd_addr[ADDR_W-1];
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
                w_to_cnt_nxt  = 8'd0;
`endif
            end
            S_ACCESS: begin
                if (w_pready) begin
                    w_psel_0_nxt    = 1'b0;
                    w_psel_1_nxt    = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : w_prdata;
                end else if (w_abort) begin
                    w_psel_0_nxt    = 1'b0;
                    w_psel_1_nxt    = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
`ifdef APB_TIMEOUT_EN
                    w_to_cnt_nxt = r_to_cnt + 8'd1;
`endif
                end
            end
            default: begin
                w_psel_0_nxt  = 1'b0;
                w_psel_1_nxt  = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign psel_0    = r_psel_0;
    assign psel_1    = r_psel_1;
    assign penable   = r_penable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge. Expected responses are queued when a
//   command is issued and compared when rsp_valid pulses; APB pin behaviour is
//   checked inline at each step.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic              presetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel_0;
    logic              psel_1;
    logic              penable;
    logic [DATA_W-1:0] prdata_0;
    logic              pready_0;
    logic [DATA_W-1:0] prdata_1;
    logic              pready_1;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    apb_master_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .presetn  (presetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .psel_0   (psel_0),
        .psel_1   (psel_1),
        .penable  (penable),
        .prdata_0 (prdata_0),
        .pready_0 (pready_0),
        .prdata_1 (prdata_1),
        .pready_1 (pready_1)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    // Response scoreboard: every pulse must match the oldest queued expectation
    always @(negedge pclk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata_0  = '0;
        prdata_1  = '0;
        pready_0  = 1'b0;
        pready_1  = 1'b0;

        // ---------------- Power-on reset ----------------
        step();
        step();
        check("rst_presetn", 32'(presetn), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_psel", {30'd0, psel_1, psel_0}, 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        step();
        check("por_presetn", 32'(presetn), 32'd1);
        check("por_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---------------- Write WDT, zero wait ----------------
        pready_0 = 1'b1;
        issue(1'b1, 8'h04, 32'hA5A5_0001);
        sb_q.push_back('{rdata: 32'd0, err: 1'b0});
        step();                                   // accept edge E
        cmd_valid = 1'b0;
        check("wr_setup_psel0", 32'(psel_0), 32'd1);
        check("wr_setup_psel1", 32'(psel_1), 32'd0);
        check("wr_setup_penable", 32'(penable), 32'd0);
        check("wr_setup_paddr", 32'(paddr), 32'h04);
        check("wr_setup_pwrite", 32'(pwrite), 32'd1);
        check("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
        check("wr_setup_cmd_ready", 32'(cmd_ready), 32'd0);
        step();                                   // E+1
        check("wr_access_psel0", 32'(psel_0), 32'd1);
        check("wr_access_penable", 32'(penable), 32'd1);
        check("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
        step();                                   // E+2
        check("wr_done_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_done_psel", {30'd0, psel_1, psel_0}, 32'd0);
        check("wr_done_penable", 32'(penable), 32'd0);
        check("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);
        step();                                   // E+3
        check("wr_pulse_width", 32'(rsp_valid), 32'd0);
        check("wr_idle_paddr_hold", 32'(paddr), 32'h04);
        pready_0 = 1'b0;

        // ---------------- Read memory, 3 wait states ----------------
        prdata_1 = 32'h1234_5678;
        pready_1 = 1'b0;
        issue(1'b0, 8'h90, 32'h0BAD_F00D);
        sb_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        step();                                   // E
        cmd_valid = 1'b0;
        check("rd_setup_psel1", 32'(psel_1), 32'd1);
        check("rd_setup_psel0", 32'(psel_0), 32'd0);
        check("rd_pwdata_loaded", pwdata, 32'h0BAD_F00D);
        step();                                   // E+1, first ACCESS cycle
        for (int i = 0; i < 3; i++) begin
            check("rd_wait_psel1", 32'(psel_1), 32'd1);
            check("rd_wait_penable", 32'(penable), 32'd1);
            check("rd_wait_paddr", 32'(paddr), 32'h90);
            check("rd_wait_pwrite", 32'(pwrite), 32'd0);
            check("rd_wait_rsp_valid", 32'(rsp_valid), 32'd0);
            step();
        end
        pready_1 = 1'b1;                          // 4th ACCESS cycle
        check("rd_wait4_penable", 32'(penable), 32'd1);
        step();
        check("rd_done_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_done_psel1", 32'(psel_1), 32'd0);
        pready_1 = 1'b0;
        prdata_1 = '0;
        step();
        check("rd_pulse_width", 32'(rsp_valid), 32'd0);
        check("rd_rdata_hold", rsp_rdata, 32'h1234_5678);

        // ---------------- Back-to-back: write 0x80, read 0x10 ----------------
        pready_0 = 1'b1;
        pready_1 = 1'b1;
        prdata_0 = 32'hCAFE_0010;
        issue(1'b1, 8'h80, 32'hDEAD_BEEF);
        sb_q.push_back('{rdata: 32'd0, err: 1'b0});
        sb_q.push_back('{rdata: 32'hCAFE_0010, err: 1'b0});
        step();                                   // E
        check("b2b_first_psel1", 32'(psel_1), 32'd1);
        check("b2b_first_psel0", 32'(psel_0), 32'd0);
        issue(1'b0, 8'h10, 32'h0000_0000);        // must wait for cmd_ready
        step();                                   // E+1
        check("b2b_ignored_paddr", 32'(paddr), 32'h80);
        step();                                   // E+2
        check("b2b_first_rsp", 32'(rsp_valid), 32'd1);
        check("b2b_ready_with_rsp", 32'(cmd_ready), 32'd1);
        step();                                   // E+3, second accept
        cmd_valid = 1'b0;
        check("b2b_second_psel0", 32'(psel_0), 32'd1);
        check("b2b_second_psel1", 32'(psel_1), 32'd0);
        check("b2b_second_paddr", 32'(paddr), 32'h10);
        check("b2b_second_rsp_low", 32'(rsp_valid), 32'd0);
        step();
        step();                                   // E+5
        check("b2b_second_rsp", 32'(rsp_valid), 32'd1);
        step();
        pready_0 = 1'b0;
        pready_1 = 1'b0;

        // ---------------- Distractor on the unselected slave ----------------
        pready_1 = 1'b1;
        prdata_1 = 32'hFFFF_FFFF;
        prdata_0 = 32'h0000_0055;
        pready_0 = 1'b0;
        issue(1'b0, 8'h20, 32'h0);
        sb_q.push_back('{rdata: 32'h0000_0055, err: 1'b0});
        step();                                   // E
        cmd_valid = 1'b0;
        step();                                   // ACCESS cycle 1
        check("dis_cyc1_psel0", 32'(psel_0), 32'd1);
        check("dis_cyc1_rsp", 32'(rsp_valid), 32'd0);
        step();                                   // ACCESS cycle 2
        check("dis_cyc2_rsp", 32'(rsp_valid), 32'd0);
        step();                                   // ACCESS cycle 3
        check("dis_cyc3_rsp", 32'(rsp_valid), 32'd0);
        pready_0 = 1'b1;
        step();
        check("dis_done_rsp", 32'(rsp_valid), 32'd1);
        check("dis_done_psel0", 32'(psel_0), 32'd0);
        step();
        pready_0 = 1'b0;
        pready_1 = 1'b0;
        prdata_1 = '0;

        // ---------------- Reset in the middle of ACCESS ----------------
        issue(1'b0, 8'h08, 32'h7777_7777);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("mid_in_access", 32'(penable), 32'd1);
        #2;
        preset = 1'b1;
        #1;
        check("mid_rst_presetn", 32'(presetn), 32'd0);
        check("mid_rst_psel", {30'd0, psel_1, psel_0}, 32'd0);
        check("mid_rst_penable", 32'(penable), 32'd0);
        check("mid_rst_paddr", 32'(paddr), 32'd0);
        check("mid_rst_pwdata", pwdata, 32'd0);
        check("mid_rst_pwrite", 32'(pwrite), 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        step();
        @(negedge pclk);
        preset = 1'b0;
        step();
        check("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rel_presetn", 32'(presetn), 32'd1);
        pready_0 = 1'b1;                          // a dropped transfer must not answer
        for (int i = 0; i < 4; i++) begin
            check("mid_rel_no_rsp", 32'(rsp_valid), 32'd0);
            step();
        end
        pready_0 = 1'b0;

        // ---------------- Stalled slave ----------------
`ifdef APB_TIMEOUT_EN
        issue(1'b0, 8'h08, 32'h0);
        sb_q.push_back('{rdata: 32'd0, err: 1'b1});
        prdata_0 = 32'h1111_2222;
        step();                                   // E
        cmd_valid = 1'b0;
        step();                                   // ACCESS cycle 1
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            step();
            check("to_no_early_abort", 32'(rsp_valid), 32'd0);
        end
        step();                                   // edge ending ACCESS cycle 16
        check("to_abort_rsp", 32'(rsp_valid), 32'd1);
        check("to_abort_psel", {30'd0, psel_1, psel_0}, 32'd0);
        check("to_abort_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
`else
        issue(1'b0, 8'h08, 32'h0);
        prdata_0 = 32'h1111_2222;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 101; i++) step();
        check("stall_psel0", 32'(psel_0), 32'd1);
        check("stall_penable", 32'(penable), 32'd1);
        check("stall_rsp", 32'(rsp_valid), 32'd0);
        check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        sb_q.push_back('{rdata: 32'h1111_2222, err: 1'b0});
        pready_0 = 1'b1;
        step();
        check("stall_release_rsp", 32'(rsp_valid), 32'd1);
        step();
        pready_0 = 1'b0;
`endif

        // ---------------- Drain ----------------
        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
